// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared combinational ALU.
// Each requester holds at most one operation: FREE -> ISSUED -> DONE -> FREE.

package alu_arbiter_pkg;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned FLAG_W  = 4;
  localparam int unsigned CTRL_W  = 4;
  localparam int unsigned TYPE_W  = 2;
  localparam int unsigned SHT_W   = 2;
  localparam int unsigned SHAMT_W = 5;
  localparam int unsigned CNT_W   = 16;

  // Operation held in the issue register.
  typedef struct packed {
    logic [DATA_W-1:0]  a;
    logic [DATA_W-1:0]  b;
    logic [CTRL_W-1:0]  ctrl;
    logic [TYPE_W-1:0]  itype;
    logic [SHT_W-1:0]   shtype;
    logic [SHAMT_W-1:0] shamt;
  } op_t;

  // Result held for a requester.
  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic [FLAG_W-1:0] flags;
    logic              dz;
  } rsp_t;
endpackage

module alu_arbiter
  import alu_arbiter_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                req0_valid,
  output logic                req0_ready,
  input  logic [DATA_W-1:0]   req0_a,
  input  logic [DATA_W-1:0]   req0_b,
  input  logic [CTRL_W-1:0]   req0_ctrl,
  input  logic [TYPE_W-1:0]   req0_type,
  input  logic [SHT_W-1:0]    req0_shtype,
  input  logic [SHAMT_W-1:0]  req0_shamt,
  input  logic                req1_valid,
  output logic                req1_ready,
  input  logic [DATA_W-1:0]   req1_a,
  input  logic [DATA_W-1:0]   req1_b,
  input  logic [CTRL_W-1:0]   req1_ctrl,
  input  logic [TYPE_W-1:0]   req1_type,
  input  logic [SHT_W-1:0]    req1_shtype,
  input  logic [SHAMT_W-1:0]  req1_shamt,
  output logic                rsp0_valid,
  input  logic                rsp0_ready,
  output logic [DATA_W-1:0]   rsp0_result,
  output logic [FLAG_W-1:0]   rsp0_flags,
  output logic                rsp0_dz,
  output logic                rsp1_valid,
  input  logic                rsp1_ready,
  output logic [DATA_W-1:0]   rsp1_result,
  output logic [FLAG_W-1:0]   rsp1_flags,
  output logic                rsp1_dz,
  output logic [DATA_W-1:0]   alu_a,
  output logic [DATA_W-1:0]   alu_b,
  output logic [CTRL_W-1:0]   alu_ctrl,
  output logic [TYPE_W-1:0]   alu_type,
  output logic [SHT_W-1:0]    alu_shtype,
  output logic [SHAMT_W-1:0]  alu_shamt,
  input  logic [DATA_W-1:0]   alu_result,
  input  logic [FLAG_W-1:0]   alu_flags,
  output logic [CNT_W-1:0]    ops_count
);

  localparam int unsigned SUM_W = CNT_W + 1;

  localparam logic [1:0] ST_FREE   = 2'b00;
  localparam logic [1:0] ST_ISSUED = 2'b01;
  localparam logic [1:0] ST_DONE   = 2'b10;

  localparam logic [CTRL_W-1:0] CTRL_UDIV = 4'b0101;
  localparam logic [TYPE_W-1:0] TYPE_REG  = 2'b00;

  logic [1:0]       st_q [2];
  logic [1:0]       st_d [2];
  logic             ptr_q, ptr_d;
  logic             iss_vld_q, iss_vld_d;
  logic             iss_owner_q, iss_owner_d;
  op_t              iss_op_q, iss_op_d;
  rsp_t             rsp_q [2];
  rsp_t             rsp_d [2];
  logic [CNT_W-1:0] ops_q, ops_d;
  logic [SUM_W-1:0] ops_sum;

  op_t              req_op [2];
  logic [1:0]       req_valid;
  logic [1:0]       rsp_ready;
  logic [1:0]       elig;
  logic [1:0]       hs;
  logic [1:0]       rdy;
  logic             grant_vld;
  logic             grant_id;

  // Gather per-requester inputs into indexable form.
  assign req_valid = {req1_valid, req0_valid};
  assign rsp_ready = {rsp1_ready, rsp0_ready};
  assign req_op[0] = '{a: req0_a, b: req0_b, ctrl: req0_ctrl, itype: req0_type,
                       shtype: req0_shtype, shamt: req0_shamt};
  assign req_op[1] = '{a: req1_a, b: req1_b, ctrl: req1_ctrl, itype: req1_type,
                       shtype: req1_shtype, shamt: req1_shamt};

  // Arbitration, issue/retire, per-requester state transitions and counter.
  always_comb begin
    st_d        = st_q;
    ptr_d       = ptr_q;
    iss_vld_d   = 1'b0;
    iss_owner_d = 1'b0;
    iss_op_d    = '0;
    rsp_d       = rsp_q;
    grant_vld   = 1'b0;
    grant_id    = ptr_q;
    rdy         = '0;
    elig        = '0;
    hs          = '0;
    ops_sum     = '0;
    ops_d       = ops_q;

    for (int i = 0; i < 2; i++) begin
      elig[i] = !reset && req_valid[i] && (st_q[i] == ST_FREE);
      hs[i]   = (st_q[i] == ST_DONE) && rsp_ready[i];
    end

    if (elig[ptr_q]) begin
      grant_vld = 1'b1;
      grant_id  = ptr_q;
    end else if (elig[~ptr_q]) begin
      grant_vld = 1'b1;
      grant_id  = ~ptr_q;
    end
    rdy[grant_id] = grant_vld;

    // The issue register is free every cycle since its op always retires.
    if (grant_vld) begin
      iss_vld_d   = 1'b1;
      iss_owner_d = grant_id;
      iss_op_d    = req_op[grant_id];
      ptr_d       = ~grant_id;
    end

    if (iss_vld_q) begin
      rsp_d[iss_owner_q] = '{result: alu_result,
                             flags:  alu_flags,
                             dz:     (iss_op_q.itype == TYPE_REG) &&
                                     (iss_op_q.ctrl == CTRL_UDIV) &&
                                     (iss_op_q.b == '0)};
    end

    for (int i = 0; i < 2; i++) begin
      case (st_q[i])
        ST_FREE:   if (grant_vld && (grant_id == 1'(i))) st_d[i] = ST_ISSUED;
        ST_ISSUED: if (iss_vld_q && (iss_owner_q == 1'(i))) st_d[i] = ST_DONE;
        ST_DONE:   if (rsp_ready[i]) st_d[i] = ST_FREE;
        default:   st_d[i] = ST_FREE;
      endcase
    end

    ops_sum = {1'b0, ops_q} + SUM_W'(hs[0]) + SUM_W'(hs[1]);
    ops_d   = ops_sum[CNT_W] ? {CNT_W{1'b1}} : ops_sum[CNT_W-1:0];
  end

  // State and datapath registers; reset overrides every other event.
  always_ff @(posedge clk) begin
    if (reset) begin
      st_q[0]     <= ST_FREE;
      st_q[1]     <= ST_FREE;
      rsp_q[0]    <= '0;
      rsp_q[1]    <= '0;
      ptr_q       <= 1'b0;
      iss_vld_q   <= 1'b0;
      iss_owner_q <= 1'b0;
      iss_op_q    <= '0;
      ops_q       <= '0;
    end else begin
      st_q        <= st_d;
      rsp_q       <= rsp_d;
      ptr_q       <= ptr_d;
      iss_vld_q   <= iss_vld_d;
      iss_owner_q <= iss_owner_d;
      iss_op_q    <= iss_op_d;
      ops_q       <= ops_d;
    end
  end

  assign req0_ready  = rdy[0];
  assign req1_ready  = rdy[1];

  assign rsp0_valid  = (st_q[0] == ST_DONE);
  assign rsp0_result = rsp_q[0].result;
  assign rsp0_flags  = rsp_q[0].flags;
  assign rsp0_dz     = rsp_q[0].dz;
  assign rsp1_valid  = (st_q[1] == ST_DONE);
  assign rsp1_result = rsp_q[1].result;
  assign rsp1_flags  = rsp_q[1].flags;
  assign rsp1_dz     = rsp_q[1].dz;

  assign alu_a       = iss_op_q.a;
  assign alu_b       = iss_op_q.b;
  assign alu_ctrl    = iss_op_q.ctrl;
  assign alu_type    = iss_op_q.itype;
  assign alu_shtype  = iss_op_q.shtype;
  assign alu_shamt   = iss_op_q.shamt;

  assign ops_count   = ops_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a stand-in ALU and per-requester scoreboards.

module tb_alu_arbiter;

  typedef struct packed {
    logic [31:0] result;
    logic [3:0]  flags;
    logic        dz;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]  req0_ctrl, req1_ctrl;
  logic [1:0]  req0_type, req1_type, req0_shtype, req1_shtype;
  logic [4:0]  req0_shamt, req1_shamt;
  logic        rsp0_valid, rsp0_ready, rsp0_dz, rsp1_valid, rsp1_ready, rsp1_dz;
  logic [31:0] rsp0_result, rsp1_result;
  logic [3:0]  rsp0_flags, rsp1_flags;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [3:0]  alu_ctrl, alu_flags;
  logic [1:0]  alu_type, alu_shtype;
  logic [4:0]  alu_shamt;
  logic [15:0] ops_count;

  int   n_pass = 0;
  int   n_fail = 0;
  int   n_total = 0;
  exp_t q0[$];
  exp_t q1[$];
  int   grant_log[$];
  int   last_acc = -1;
  logic ptr_m = 1'b0;
  logic [1:0] busy_m = 2'b00;

  alu_arbiter dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_ctrl(req0_ctrl), .req0_type(req0_type), .req0_shtype(req0_shtype), .req0_shamt(req0_shamt),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_ctrl(req1_ctrl), .req1_type(req1_type), .req1_shtype(req1_shtype), .req1_shamt(req1_shamt),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result),
    .rsp0_flags(rsp0_flags), .rsp0_dz(rsp0_dz),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result),
    .rsp1_flags(rsp1_flags), .rsp1_dz(rsp1_dz),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_type(alu_type),
    .alu_shtype(alu_shtype), .alu_shamt(alu_shamt),
    .alu_result(alu_result), .alu_flags(alu_flags), .ops_count(ops_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in ALU: {flags, result}
  function automatic logic [35:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] ctrl, input logic [1:0] typ,
                                            input logic [1:0] sht, input logic [4:0] shamt);
    logic [31:0] r;
    logic [3:0]  f;
    case (ctrl)
      4'b0000: r = a + b;
      4'b0001: r = a - b;
      4'b0010: r = a & b;
      4'b0011: r = a | b;
      4'b0101: r = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      4'b0110: r = (sht == 2'b00) ? (a << shamt) : (a >> shamt);
      default: r = a ^ b;
    endcase
    f = {r[31], (r == 32'd0), typ[0] ^ sht[1], typ[1] ^ sht[0]};
    return {f, r};
  endfunction

  always_comb {alu_flags, alu_result} = alu_model(alu_a, alu_b, alu_ctrl, alu_type, alu_shtype, alu_shamt);

  function automatic exp_t expect_of(input logic [31:0] a, input logic [31:0] b,
                                     input logic [3:0] ctrl, input logic [1:0] typ,
                                     input logic [1:0] sht, input logic [4:0] shamt);
    logic [35:0] m;
    exp_t e;
    m = alu_model(a, b, ctrl, typ, sht, shamt);
    e.result = m[31:0];
    e.flags  = m[35:32];
    e.dz     = (typ == 2'b00) && (ctrl == 4'b0101) && (b == 32'd0);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int id, input logic [31:0] a, input logic [31:0] b, input logic [3:0] ctrl,
                       input logic [1:0] typ, input logic [1:0] sht, input logic [4:0] shamt);
    if (id == 0) begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_ctrl = ctrl;
      req0_type = typ; req0_shtype = sht; req0_shamt = shamt;
    end else begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_ctrl = ctrl;
      req1_type = typ; req1_shtype = sht; req1_shamt = shamt;
    end
  endtask

  task automatic drive_rand(input int id);
    logic [3:0]  c;
    logic [31:0] b;
    case ($urandom_range(0, 5))
      0: c = 4'b0000;
      1: c = 4'b0001;
      2: c = 4'b0010;
      3: c = 4'b0011;
      4: c = 4'b0101;
      default: c = 4'b0110;
    endcase
    b = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
    drive(id, $urandom, b, c, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
          5'($urandom_range(0, 31)));
  endtask

  task automatic idle(input int id);
    if (id == 0) req0_valid = 1'b0;
    else         req1_valid = 1'b0;
  endtask

  task automatic check_rsp(input int id);
    exp_t        e;
    logic [31:0] r;
    logic [3:0]  f;
    logic        d;
    int          n;
    if (id == 0) begin n = q0.size(); r = rsp0_result; f = rsp0_flags; d = rsp0_dz; end
    else         begin n = q1.size(); r = rsp1_result; f = rsp1_flags; d = rsp1_dz; end
    chk($sformatf("rsp%0d_expected_pending", id), 32'(n != 0), 32'd1);
    if (n != 0) begin
      if (id == 0) e = q0.pop_front();
      else         e = q1.pop_front();
      chk($sformatf("rsp%0d_result", id), r, e.result);
      chk($sformatf("rsp%0d_flags", id), 32'(f), 32'(e.flags));
      chk($sformatf("rsp%0d_dz", id), 32'(d), 32'(e.dz));
    end
  endtask

  // One clock: check arbitration and handshakes before the edge, update the model at it.
  task automatic step();
    logic e0, e1, r0, r1, hs0, hs1;
    @(negedge clk);
    r0 = 1'b0; r1 = 1'b0; hs0 = 1'b0; hs1 = 1'b0;
    if (reset) begin
      chk("req0_ready_in_reset", 32'(req0_ready), 32'd0);
      chk("req1_ready_in_reset", 32'(req1_ready), 32'd0);
    end else begin
      e0 = req0_valid && !busy_m[0];
      e1 = req1_valid && !busy_m[1];
      r0 = e0 && (!ptr_m || !e1);
      r1 = e1 && (ptr_m || !e0);
      chk("req0_ready", 32'(req0_ready), 32'(r0));
      chk("req1_ready", 32'(req1_ready), 32'(r1));
      hs0 = rsp0_valid && rsp0_ready;
      hs1 = rsp1_valid && rsp1_ready;
      if (hs0) check_rsp(0);
      if (hs1) check_rsp(1);
      if (r0) q0.push_back(expect_of(req0_a, req0_b, req0_ctrl, req0_type, req0_shtype, req0_shamt));
      if (r1) q1.push_back(expect_of(req1_a, req1_b, req1_ctrl, req1_type, req1_shtype, req1_shamt));
    end
    @(posedge clk);
    last_acc = -1;
    if (reset) begin
      q0.delete(); q1.delete();
      busy_m = 2'b00;
      ptr_m  = 1'b0;
    end else begin
      if (hs0) busy_m[0] = 1'b0;
      if (hs1) busy_m[1] = 1'b0;
      if (r0) begin busy_m[0] = 1'b1; ptr_m = 1'b1; last_acc = 0; grant_log.push_back(0); end
      if (r1) begin busy_m[1] = 1'b1; ptr_m = 1'b0; last_acc = 1; grant_log.push_back(1); end
    end
    #1;
  endtask

  initial begin
    exp_t hold_e;
    int   served1;

    reset = 1'b1;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_ctrl = '0; req0_type = '0; req0_shtype = '0; req0_shamt = '0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_ctrl = '0; req1_type = '0; req1_shtype = '0; req1_shamt = '0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    step(); step();
    reset = 1'b0;

    // Reset state
    chk("rst_rsp0_valid", 32'(rsp0_valid), 32'd0);
    chk("rst_rsp1_valid", 32'(rsp1_valid), 32'd0);
    chk("rst_rsp0_result", rsp0_result, 32'd0);
    chk("rst_rsp1_dz", 32'(rsp1_dz), 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_ctrl", 32'(alu_ctrl), 32'd0);
    chk("rst_ops_count", 32'(ops_count), 32'd0);

    // ADD 5+3 on requester 0, two-cycle latency
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    drive(0, 32'd5, 32'd3, 4'b0000, 2'b00, 2'b00, 5'd0);
    step();
    idle(0);
    chk("add_c2_rsp0_valid", 32'(rsp0_valid), 32'd0);
    chk("add_c2_alu_a", alu_a, 32'd5);
    chk("add_c2_alu_b", alu_b, 32'd3);
    step();
    chk("add_c3_rsp0_valid", 32'(rsp0_valid), 32'd1);
    chk("add_c3_result", rsp0_result, 32'd8);
    chk("add_c3_alu_idle", alu_a, 32'd0);
    step();
    chk("add_ops_count", 32'(ops_count), 32'd1);
    chk("add_rsp0_released", 32'(rsp0_valid), 32'd0);

    // UDIV by zero on requester 1
    drive(1, 32'd7, 32'd0, 4'b0101, 2'b00, 2'b00, 5'd0);
    step(); idle(1); step();
    chk("udiv_rsp1_valid", 32'(rsp1_valid), 32'd1);
    chk("udiv_result", rsp1_result, 32'hFFFF_FFFF);
    chk("udiv_dz", 32'(rsp1_dz), 32'd1);
    step();
    // Same divide as an IMM op does not flag divide-by-zero
    drive(1, 32'd9, 32'd0, 4'b0101, 2'b01, 2'b00, 5'd0);
    step(); idle(1); step();
    chk("udiv_imm_dz", 32'(rsp1_dz), 32'd0);
    step();
    chk("udiv_ops_count", 32'(ops_count), 32'd3);

    // Both requesters continuously valid: grants alternate
    grant_log.delete();
    drive_rand(0); drive_rand(1);
    repeat (12) begin
      step();
      if (last_acc >= 0) drive_rand(last_acc);
    end
    idle(0); idle(1);
    repeat (4) step();
    chk("alt_grant_count", 32'(grant_log.size()), 32'd8);
    for (int i = 0; i < grant_log.size(); i++)
      chk($sformatf("alt_grant_%0d", i), 32'(grant_log[i]), 32'(i % 2));

    // Requester 0 result held under back-pressure while requester 1 is served
    rsp0_ready = 1'b0;
    hold_e = expect_of(32'd2, 32'd2, 4'b0001, 2'b00, 2'b00, 5'd0);
    drive(0, 32'd2, 32'd2, 4'b0001, 2'b00, 2'b00, 5'd0);
    step(); idle(0); step();
    drive(0, 32'd11, 32'd22, 4'b0000, 2'b00, 2'b00, 5'd0);
    drive_rand(1);
    served1 = 0;
    for (int k = 0; k < 5; k++) begin
      step();
      chk($sformatf("hold_valid_%0d", k), 32'(rsp0_valid), 32'd1);
      chk($sformatf("hold_result_%0d", k), rsp0_result, 32'd0);
      chk($sformatf("hold_flags_%0d", k), 32'(rsp0_flags), 32'(hold_e.flags));
      chk($sformatf("hold_req0_ready_%0d", k), 32'(req0_ready), 32'd0);
      if (last_acc == 1) begin served1++; drive_rand(1); end
    end
    chk("hold_req1_served", 32'(served1 >= 1), 32'd1);
    idle(1);
    rsp0_ready = 1'b1;
    step();
    step();
    chk("hold_reaccept_req0", 32'(last_acc), 32'd0);
    idle(0);
    repeat (4) step();

    // Reset one cycle after an accept discards the operation
    drive(0, 32'd100, 32'd23, 4'b0000, 2'b00, 2'b00, 5'd0);
    step();
    idle(0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("midrst_rsp0_valid", 32'(rsp0_valid), 32'd0);
    chk("midrst_alu_a", alu_a, 32'd0);
    chk("midrst_alu_b", alu_b, 32'd0);
    chk("midrst_ops_count", 32'(ops_count), 32'd0);
    step(); step();
    chk("midrst_no_rsp0", 32'(rsp0_valid), 32'd0);
    chk("midrst_no_rsp1", 32'(rsp1_valid), 32'd0);
    drive_rand(0); drive_rand(1);
    step();
    chk("midrst_ptr_grant0", 32'(last_acc), 32'd0);
    idle(0);
    step();
    idle(1);
    repeat (4) step();

    // Counter saturation with simultaneous handshakes
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    drive_rand(0); drive_rand(1);
    step(); idle(0);
    step(); idle(1);
    step();
    chk("sat_rsp0_valid", 32'(rsp0_valid), 32'd1);
    chk("sat_rsp1_valid", 32'(rsp1_valid), 32'd1);
    force dut.ops_q = 16'hFFFE;
    step();
    release dut.ops_q;
    chk("sat_preload", 32'(ops_count), 32'h0000_FFFE);
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    step();
    chk("sat_double_hs", 32'(ops_count), 32'h0000_FFFF);
    chk("sat_rsp0_released", 32'(rsp0_valid), 32'd0);
    chk("sat_rsp1_released", 32'(rsp1_valid), 32'd0);
    drive_rand(0);
    step(); idle(0);
    step(); step();
    chk("sat_stays", 32'(ops_count), 32'h0000_FFFF);

    chk("scoreboard_drained", 32'(q0.size() + q1.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
